// File: rtl/calc_pkg.sv
// Shared encodings for the calculator front-end: operator codes, sequencer
// states, result width and the BCD range helper.
package calc_pkg;

   typedef enum logic [1:0] {
      OP_ADD = 2'd0,
      OP_SUB = 2'd1,
      OP_MUL = 2'd2,
      OP_DIV = 2'd3
   } op_e;

   typedef enum logic [2:0] {
      ST_ENTER_A = 3'd0,
      ST_ENTER_B = 3'd1,
      ST_EXEC    = 3'd2,
      ST_SHOW    = 3'd3,
      ST_ERR     = 3'd4
   } state_e;

   localparam int RES_W = 14;

   function automatic logic is_bcd(input logic [3:0] dig);
      return (dig <= 4'd9);
   endfunction

endpackage

// File: rtl/bcd_entry_reg.sv
// Two-digit BCD entry register: a key shifts in as units, the old units become
// tens. Clear and load in the same cycle yields 0 tens with the new digit as units.
module bcd_entry_reg
   import calc_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       clr_i,
   input  logic       load_i,
   input  logic [3:0] digit_i,
   output logic [3:0] tens_o,
   output logic [3:0] units_o,
   output logic       has_digit_o
);

   logic [3:0] tens_q, tens_d;
   logic [3:0] units_q, units_d;
   logic       has_q, has_d;

   always_comb begin
      tens_d  = tens_q;
      units_d = units_q;
      has_d   = has_q;
      if (load_i && is_bcd(digit_i)) begin
         tens_d  = clr_i ? 4'd0 : units_q;
         units_d = digit_i;
         has_d   = 1'b1;
      end else if (clr_i) begin
         tens_d  = 4'd0;
         units_d = 4'd0;
         has_d   = 1'b0;
      end else begin
         has_d   = has_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tens_q  <= 4'd0;
         units_q <= 4'd0;
         has_q   <= 1'b0;
      end else begin
         tens_q  <= tens_d;
         units_q <= units_d;
         has_q   <= has_d;
      end
   end

   assign tens_o      = tens_q;
   assign units_o     = units_q;
   assign has_digit_o = has_q;

endmodule

// File: rtl/calc_sequencer.sv
// Calculator front-end sequencer: operand/operator entry, datapath start/wait,
// result hold. Optional EXEC watchdog enabled by defining CALC_WDOG_EN.
module calc_sequencer
   import calc_pkg::*;
   #(parameter int unsigned WDOG_CYCLES = 64)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             digit_valid,
   input  logic [3:0]       digit,
   input  logic             op_valid,
   input  logic [1:0]       op,
   input  logic             eq,
   input  logic             clr,
   input  logic             exec_done,
   input  logic [RES_W-1:0] exec_result,
   input  logic             exec_neg,
   output logic [3:0]       a,
   output logic [3:0]       b,
   output logic [3:0]       c,
   output logic [3:0]       d,
   output logic [1:0]       op_sel,
   output logic             exec_start,
   output logic [RES_W-1:0] result_q,
   output logic             neg_q,
   output logic             res_valid,
   output logic             busy,
   output logic             err
);

   state_e           state_q, state_d;
   logic [1:0]       op_sel_q, op_sel_d;
   logic [RES_W-1:0] result_d;
   logic             neg_d;
   logic             exec_start_q, exec_start_d;
   logic             a_clr_s, a_load_s, b_clr_s, b_load_s;
   logic             b_has_s, a_has_unused_s;
   logic             eq_s, op_s, dig_s, b_zero_s, wdog_exp_s;

   // Only the highest-priority strobe of a cycle is acted on (clr handled first).
   assign eq_s     = eq;
   assign op_s     = op_valid && !eq;
   assign dig_s    = digit_valid && is_bcd(digit) && !eq && !op_valid;
   assign b_zero_s = (c == 4'd0) && (d == 4'd0);

   bcd_entry_reg u_a (
      .clk         (clk),
      .rst         (rst),
      .clr_i       (a_clr_s),
      .load_i      (a_load_s),
      .digit_i     (digit),
      .tens_o      (a),
      .units_o     (b),
      .has_digit_o (a_has_unused_s)
   );

   bcd_entry_reg u_b (
      .clk         (clk),
      .rst         (rst),
      .clr_i       (b_clr_s),
      .load_i      (b_load_s),
      .digit_i     (digit),
      .tens_o      (c),
      .units_o     (d),
      .has_digit_o (b_has_s)
   );

`ifdef CALC_WDOG_EN
   localparam int unsigned WD_W = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
   logic [WD_W-1:0] wdog_q, wdog_d;

   assign wdog_exp_s = (wdog_q == {WD_W{1'b0}});

   // Loaded with the start pulse; reaching zero in EXEC marks the last allowed cycle.
   always_comb begin
      wdog_d = wdog_q;
      if (exec_start_d) begin
         wdog_d = WD_W'(WDOG_CYCLES - 1);
      end else if ((state_q == ST_EXEC) && !wdog_exp_s) begin
         wdog_d = wdog_q - {{(WD_W-1){1'b0}}, 1'b1};
      end else begin
         wdog_d = wdog_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wdog_q <= {WD_W{1'b0}};
      end else begin
         wdog_q <= wdog_d;
      end
   end
`else
   assign wdog_exp_s = 1'b0;
`endif

   always_comb begin
      state_d      = state_q;
      op_sel_d     = op_sel_q;
      result_d     = result_q;
      neg_d        = neg_q;
      exec_start_d = 1'b0;
      a_clr_s      = 1'b0;
      a_load_s     = 1'b0;
      b_clr_s      = 1'b0;
      b_load_s     = 1'b0;
      if (clr) begin
         state_d  = ST_ENTER_A;
         op_sel_d = OP_ADD;
         result_d = {RES_W{1'b0}};
         neg_d    = 1'b0;
         a_clr_s  = 1'b1;
         b_clr_s  = 1'b1;
      end else begin
         case (state_q)
            ST_ENTER_A: begin
               if (op_s) begin
                  op_sel_d = op;
                  b_clr_s  = 1'b1;
                  state_d  = ST_ENTER_B;
               end else begin
                  a_load_s = dig_s;
               end
            end
            ST_ENTER_B: begin
               if (eq_s && b_has_s) begin
                  if ((op_sel_q == OP_DIV) && b_zero_s) begin
                     state_d = ST_ERR;
                  end else begin
                     state_d      = ST_EXEC;
                     exec_start_d = 1'b1;
                  end
               end else if (op_s && !b_has_s) begin
                  op_sel_d = op;
               end else begin
                  b_load_s = dig_s;
               end
            end
            ST_EXEC: begin
               // A completion in the expiry cycle still counts as success.
               if (exec_done) begin
                  result_d = exec_result;
                  neg_d    = exec_neg;
                  state_d  = ST_SHOW;
               end else if (wdog_exp_s) begin
                  state_d = ST_ERR;
               end else begin
                  state_d = ST_EXEC;
               end
            end
            ST_SHOW: begin
               if (dig_s) begin
                  a_clr_s  = 1'b1;
                  b_clr_s  = 1'b1;
                  a_load_s = 1'b1;
                  state_d  = ST_ENTER_A;
               end else begin
                  state_d = ST_SHOW;
               end
            end
            ST_ERR: begin
               state_d = ST_ERR;
            end
            default: begin
               state_d = ST_ENTER_A;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_ENTER_A;
         op_sel_q     <= OP_ADD;
         result_q     <= {RES_W{1'b0}};
         neg_q        <= 1'b0;
         exec_start_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         op_sel_q     <= op_sel_d;
         result_q     <= result_d;
         neg_q        <= neg_d;
         exec_start_q <= exec_start_d;
      end
   end

   assign op_sel     = op_sel_q;
   assign exec_start = exec_start_q;
   assign res_valid  = (state_q == ST_SHOW);
   assign busy       = (state_q == ST_EXEC);
   assign err        = (state_q == ST_ERR);

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed bench for calc_sequencer with a start/result scoreboard and a
// simple datapath responder (delay programmable, or never responds).
module tb_calc_sequencer;
   import calc_pkg::*;

   logic        clk = 1'b0;
   logic        rst, digit_valid, op_valid, eq, clr;
   logic [3:0]  digit;
   logic [1:0]  op;
   logic        exec_done, exec_neg;
   logic [13:0] exec_result;
   logic [3:0]  a, b, c, d;
   logic [1:0]  op_sel;
   logic        exec_start, neg_q, res_valid, busy, err;
   logic [13:0] result_q;

   always #5 clk = ~clk;

   calc_sequencer #(.WDOG_CYCLES(4)) dut (
      .clk(clk), .rst(rst), .digit_valid(digit_valid), .digit(digit),
      .op_valid(op_valid), .op(op), .eq(eq), .clr(clr),
      .exec_done(exec_done), .exec_result(exec_result), .exec_neg(exec_neg),
      .a(a), .b(b), .c(c), .d(d), .op_sel(op_sel), .exec_start(exec_start),
      .result_q(result_q), .neg_q(neg_q), .res_valid(res_valid),
      .busy(busy), .err(err)
   );

   typedef struct packed {logic [3:0] a, b, c, d; logic [1:0] op;} start_t;
   typedef struct packed {logic [13:0] res; logic neg;} res_t;

   start_t exp_start_q[$];
   res_t   exp_res_q[$];
   int     n_tests = 0;
   int     n_fail  = 0;

   int          dp_delay = 0;
   bit          dp_never = 1'b0;
   logic [13:0] dp_result = 14'd0;
   logic        dp_neg = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic press(input logic dv, input logic [3:0] dg, input logic ov,
                        input logic [1:0] o, input logic e, input logic cl);
      digit_valid = dv; digit = dg; op_valid = ov; op = o; eq = e; clr = cl;
      @(negedge clk);
      digit_valid = 1'b0; op_valid = 1'b0; eq = 1'b0; clr = 1'b0;
   endtask

   task automatic key_d(input logic [3:0] v);  press(1'b1, v, 1'b0, 2'd0, 1'b0, 1'b0); endtask
   task automatic key_op(input logic [1:0] o); press(1'b0, 4'd0, 1'b1, o, 1'b0, 1'b0); endtask
   task automatic key_eq();                    press(1'b0, 4'd0, 1'b0, 2'd0, 1'b1, 1'b0); endtask
   task automatic key_clr();                   press(1'b0, 4'd0, 1'b0, 2'd0, 1'b0, 1'b1); endtask
   task automatic idle(input int n);           repeat (n) @(negedge clk); endtask

   task automatic expect_run(input start_t s, input bit with_res, input res_t r);
      exp_start_q.push_back(s);
      if (with_res) exp_res_q.push_back(r);
   endtask

   // Datapath model: answers an exec_start after dp_delay cycles.
   initial begin
      exec_done = 1'b0; exec_result = 14'd0; exec_neg = 1'b0;
      forever begin
         @(negedge clk);
         if (exec_start === 1'b1) begin
            repeat (dp_delay) @(negedge clk);
            if (!dp_never) begin
               exec_done = 1'b1; exec_result = dp_result; exec_neg = dp_neg;
               @(negedge clk);
               exec_done = 1'b0;
            end
         end
      end
   end

   // Monitor: start pulses and result arrivals are popped against the scoreboard.
   initial begin
      logic   prev_rv, prev_st;
      start_t es;
      res_t   er;
      prev_rv = 1'b0; prev_st = 1'b0;
      forever begin
         @(negedge clk);
         if (exec_start === 1'b1) begin
            if (prev_st) begin
               n_tests++; n_fail++;
               $display("FAIL start_pulse_width: exec_start high two cycles, required one");
            end else if (exp_start_q.size() == 0) begin
               n_tests++; n_fail++;
               $display("FAIL unexpected_start: exec_start=1 with none expected");
            end else begin
               es = exp_start_q.pop_front();
               check("start_operands", {16'd0, a, b, c, d, op_sel}, {16'd0, es});
            end
         end
         if ((res_valid === 1'b1) && !prev_rv) begin
            if (exp_res_q.size() == 0) begin
               n_tests++; n_fail++;
               $display("FAIL unexpected_result: res_valid rose with none expected, result_q=%0d", result_q);
            end else begin
               er = exp_res_q.pop_front();
               check("result", {17'd0, result_q, neg_q}, {17'd0, er});
            end
         end
         prev_st = exec_start;
         prev_rv = res_valid;
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; digit_valid = 1'b0; digit = 4'd0; op_valid = 1'b0;
      op = 2'd0; eq = 1'b0; clr = 1'b0;
      idle(3);
      rst = 1'b0;
      check("reset_digits", {a, b, c, d}, 16'h0000);
      check("reset_flags", {op_sel, exec_start, res_valid, busy, err, neg_q}, 7'd0);
      check("reset_result", result_q, 14'd0);

      // 42 + 17 with a same-cycle completion
      dp_delay = 0; dp_never = 1'b0; dp_result = 14'd59; dp_neg = 1'b0;
      key_d(4'd4);
      check("a_after_4", {a, b}, 8'h04);
      key_d(4'd2);
      check("a_after_42", {a, b}, 8'h42);
      key_op(OP_ADD);
      key_d(4'd1); key_d(4'd7);
      check("b_after_17", {a, b, c, d}, 16'h4217);
      expect_run({4'd4, 4'd2, 4'd1, 4'd7, OP_ADD}, 1'b1, {14'd59, 1'b0});
      key_eq();
      check("add_exec_cycle", {exec_start, busy}, 2'b11);
      idle(1);
      check("add_show", {res_valid, busy, err}, 3'b100);
      check("add_result_held", result_q, 14'd59);
      key_d(4'd5);
      check("show_digit_restarts", {a, b, c, d, 3'd0, res_valid}, {16'h0500, 4'd0});

      // last two digits kept, out-of-range key ignored
      key_clr();
      key_d(4'd1); key_d(4'd2); key_d(4'd3);
      check("overflow_keeps_23", {a, b}, 8'h23);
      key_d(4'd12);
      check("bad_digit_ignored", {a, b}, 8'h23);

      // operator replace, eq gating, operator locked after a B digit
      key_op(OP_ADD); key_op(OP_SUB);
      check("op_replaced", op_sel, OP_SUB);
      key_eq(); idle(2);
      check("eq_no_b_digit", {busy, err}, 2'b00);
      key_d(4'd6); key_op(OP_MUL);
      check("op_locked", op_sel, OP_SUB);
      dp_delay = 2; dp_result = 14'd17;
      expect_run({4'd2, 4'd3, 4'd0, 4'd6, OP_SUB}, 1'b1, {14'd17, 1'b0});
      key_eq();
      idle(2);
      check("busy_through_done", busy, 1'b1);
      idle(1);
      check("sub_show", {res_valid, result_q}, {1'b1, 14'd17});

      // same-cycle priority: op beats digit, clr beats digit
      key_clr(); key_d(4'd9);
      press(1'b1, 4'd3, 1'b1, OP_MUL, 1'b0, 1'b0);
      check("op_beats_digit", {a, b, c, d, 2'd0, op_sel}, {16'h0900, 4'd2});
      press(1'b1, 4'd4, 1'b0, 2'd0, 1'b0, 1'b1);
      check("clr_beats_digit", {a, b, c, d, 2'd0, op_sel}, 20'd0);

      // divide by zero
      key_d(4'd8); key_op(OP_DIV); key_d(4'd0); key_eq();
      check("div0_err", {err, busy, res_valid}, 3'b100);
      key_d(4'd5); key_op(OP_ADD); key_eq();
      check("err_ignores_keys", {err, a, b, c, d, 2'd0, op_sel}, {1'b1, 16'h0800, 4'd3});
      key_clr();
      check("clr_from_err", {a, b, c, d, op_sel, result_q, neg_q, res_valid, busy, err, exec_start},
            37'd0);

      // negative result capture: 05 - 09
      dp_delay = 0; dp_result = 14'd4; dp_neg = 1'b1;
      key_d(4'd5); key_op(OP_SUB); key_d(4'd9);
      expect_run({4'd0, 4'd5, 4'd0, 4'd9, OP_SUB}, 1'b1, {14'd4, 1'b1});
      key_eq(); idle(1);
      check("neg_result", {res_valid, neg_q, result_q}, {1'b1, 1'b1, 14'd4});

      // abort during EXEC, late completion must be ignored
      key_clr();
      dp_delay = 5; dp_result = 14'd6; dp_neg = 1'b0;
      key_d(4'd3); key_op(OP_MUL); key_d(4'd2);
      expect_run({4'd0, 4'd3, 4'd0, 4'd2, OP_MUL}, 1'b0, {14'd0, 1'b0});
      key_eq();
      check("abort_busy", busy, 1'b1);
      key_clr();
      check("abort_enter_a", {busy, res_valid, a, b, c, d}, 18'd0);
      idle(8);
      check("late_done_ignored", {res_valid, busy, result_q}, 16'd0);

`ifdef CALC_WDOG_EN
      // watchdog expiry after four EXEC cycles
      key_clr(); dp_never = 1'b1; dp_delay = 0;
      key_d(4'd1); key_op(OP_ADD); key_d(4'd1);
      expect_run({4'd0, 4'd1, 4'd0, 4'd1, OP_ADD}, 1'b0, {14'd0, 1'b0});
      key_eq(); idle(3);
      check("wdog_still_exec", {busy, err}, 2'b10);
      idle(1);
      check("wdog_expired", {busy, err, res_valid}, 3'b010);
      // completion on the expiry cycle wins
      key_clr(); dp_never = 1'b0; dp_delay = 3; dp_result = 14'd2;
      key_d(4'd1); key_op(OP_ADD); key_d(4'd1);
      expect_run({4'd0, 4'd1, 4'd0, 4'd1, OP_ADD}, 1'b1, {14'd2, 1'b0});
      key_eq(); idle(3);
      check("wdog_last_cycle", busy, 1'b1);
      idle(1);
      check("wdog_done_wins", {res_valid, err, result_q}, {1'b1, 1'b0, 14'd2});
`else
      // without the watchdog EXEC waits indefinitely
      key_clr(); dp_never = 1'b1; dp_delay = 0;
      key_d(4'd1); key_op(OP_ADD); key_d(4'd1);
      expect_run({4'd0, 4'd1, 4'd0, 4'd1, OP_ADD}, 1'b0, {14'd0, 1'b0});
      key_eq(); idle(20);
      check("exec_waits", {busy, err}, 2'b10);
      key_clr();
      check("exec_clr_exit", busy, 1'b0);
`endif

      idle(2);
      check("start_queue_drained", exp_start_q.size(), 32'd0);
      check("result_queue_drained", exp_res_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
